// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_subtractor_pkg;

  // Controller state encoding; 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake plus operand/result bus between a controlling FSM
// (master) and the serial subtract engine (slave).
interface serial_subtractor_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;

  modport master (
    output start, a, b,
    input  ready, busy, done, diff, borrow, zero
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, diff, borrow, zero
  );
endinterface

// File: rtl/serial_subtractor_half_subtractor.sv
// Half subtractor cell: difference and borrow-out of a single bit a - b.
module half_subtractor (
  input  logic i_a,
  input  logic i_b,
  output logic o_d,
  output logic o_bo
);

  assign o_d  = i_a ^ i_b;
  assign o_bo = ~i_a & i_b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// state   | meaning
// IDLE    | ready for a new operation, start sampled each edge
// RUN     | consuming one operand bit per edge, W edges total
// DONE    | one-cycle done pulse, results valid
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(W);

  state_t         r_state;
  state_t         w_next_state;
  logic [W-1:0]   r_a_sh;
  logic [W-1:0]   r_b_sh;
  logic [W-1:0]   r_d_sh;
  logic           r_bflop;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_diff;
  logic           r_borrow;
  logic           r_zero;

  logic           w_last;
  logic           w_d1;
  logic           w_bo1;
  logic           w_d_bit;
  logic           w_bo2;
  logic           w_bflop_next;
  logic [W-1:0]   w_d_sh_next;

  // Full-subtract bit cell: two half subtractors and an OR on the borrows.
  half_subtractor u_hs_ab (
    .i_a  (r_a_sh[0]),
    .i_b  (r_b_sh[0]),
    .o_d  (w_d1),
    .o_bo (w_bo1)
  );

  half_subtractor u_hs_bin (
    .i_a  (w_d1),
    .i_b  (r_bflop),
    .o_d  (w_d_bit),
    .o_bo (w_bo2)
  );

  assign w_bflop_next = w_bo1 | w_bo2;
  assign w_d_sh_next  = {w_d_bit, r_d_sh[W-1:1]};
  // Counter stops at W-1 so it never needs a wider register.
  assign w_last       = (r_cnt == CW'(W - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE: w_next_state = bus.start ? ST_RUN : ST_IDLE;
      ST_RUN:  w_next_state = w_last ? ST_DONE : ST_RUN;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Operand load, bit-serial datapath and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_d_sh   <= '0;
      r_bflop  <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_d_sh  <= '0;
            r_bflop <= 1'b0;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          r_a_sh  <= {1'b0, r_a_sh[W-1:1]};
          r_b_sh  <= {1'b0, r_b_sh[W-1:1]};
          r_d_sh  <= w_d_sh_next;
          r_bflop <= w_bflop_next;
          if (w_last) begin
            r_diff   <= w_d_sh_next;
            r_borrow <= w_bflop_next;
            r_zero   <= (w_d_sh_next == '0);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready  = (r_state == ST_IDLE);
  assign bus.busy   = (r_state == ST_RUN);
  assign bus.done   = (r_state == ST_DONE);
  assign bus.diff   = r_diff;
  assign bus.borrow = r_borrow;
  assign bus.zero   = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for the serial subtractor at W=8 and W=2.
module tb_serial_subtractor;

  typedef struct {
    int d;
    int bo;
    int z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q8[$];
  exp_t q2[$];
  logic prev_done8 = 1'b0;
  logic prev_done2 = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.W(8)) if8 ();
  serial_subtractor_if #(.W(2)) if2 ();

  serial_subtractor #(.W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_subtractor #(.W(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int w);
    exp_t e;
    int   mask;
    mask = (1 << w) - 1;
    e.d  = (a - b) & mask;
    e.bo = (a < b) ? 1 : 0;
    e.z  = (e.d == 0) ? 1 : 0;
    return e;
  endfunction

  // Result monitors: pop expected values whenever done pulses.
  always @(negedge clk) begin
    if (if8.done) begin
      check_val("done8_width", 32'(prev_done8), 32'd0);
      if (q8.size() == 0) begin
        check_val("done8_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check_val("diff8", 32'(if8.diff), e.d);
        check_val("borrow8", 32'(if8.borrow), e.bo);
        check_val("zero8", 32'(if8.zero), e.z);
      end
    end
    prev_done8 = if8.done;
  end

  always @(negedge clk) begin
    if (if2.done) begin
      check_val("done2_width", 32'(prev_done2), 32'd0);
      if (q2.size() == 0) begin
        check_val("done2_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check_val("diff2", 32'(if2.diff), e.d);
        check_val("borrow2", 32'(if2.borrow), e.bo);
        check_val("zero2", 32'(if2.zero), e.z);
      end
    end
    prev_done2 = if2.done;
  end

  // One W=8 operation; start pulsed for one edge, latency counted in edges.
  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int lat;
    @(negedge clk);
    check_val("ready8_pre", 32'(if8.ready), 32'd1);
    if8.start = 1'b1;
    if8.a = a;
    if8.b = b;
    q8.push_back(model(a, b, 8));
    @(negedge clk);
    if8.start = 1'b0;
    if8.a = ~a;
    if8.b = ~b;
    lat = 1;
    while (!if8.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("latency8", 32'(lat), 32'd9);
    @(negedge clk);
    check_val("ready8_after", 32'(if8.ready), 32'd1);
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b);
    int lat;
    @(negedge clk);
    if2.start = 1'b1;
    if2.a = a;
    if2.b = b;
    q2.push_back(model(a, b, 2));
    @(negedge clk);
    if2.start = 1'b0;
    lat = 1;
    while (!if2.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_val("latency2", 32'(lat), 32'd3);
    @(negedge clk);
    check_val("ready2_after", 32'(if2.ready), 32'd1);
  endtask

  initial begin
    int lat;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    if2.start = 1'b0; if2.a = '0; if2.b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_ready", 32'(if8.ready), 32'd1);
    check_val("rst_busy", 32'(if8.busy), 32'd0);
    check_val("rst_done", 32'(if8.done), 32'd0);
    check_val("rst_diff", 32'(if8.diff), 32'd0);
    check_val("rst_borrow", 32'(if8.borrow), 32'd0);
    check_val("rst_zero", 32'(if8.zero), 32'd0);
    rst_n = 1'b1;

    // Directed cases, including busy during RUN.
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'd100; if8.b = 8'd37;
    q8.push_back(model(100, 37, 8));
    @(negedge clk);
    if8.start = 1'b0;
    check_val("busy_run", 32'(if8.busy), 32'd1);
    check_val("ready_run", 32'(if8.ready), 32'd0);
    lat = 1;
    while (!if8.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("latency_first", 32'(lat), 32'd9);
    @(negedge clk);

    op8(8'd5, 8'd9);
    op8(8'hA5, 8'hA5);
    op8(8'd0, 8'd255);
    check_val("hold_diff", 32'(if8.diff), 32'd1);
    check_val("hold_borrow", 32'(if8.borrow), 32'd1);

    // Start held high through RUN with changing operands: one result only.
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'd50; if8.b = 8'd20;
    q8.push_back(model(50, 20, 8));
    @(negedge clk);
    if8.a = 8'd7; if8.b = 8'd3;
    lat = 1;
    while (!if8.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if8.start = 1'b0;
    check_val("latency_held", 32'(lat), 32'd9);
    @(negedge clk);
    check_val("ready_held", 32'(if8.ready), 32'd1);
    check_val("done_held", 32'(if8.done), 32'd0);

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'd100; if8.b = 8'd37;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("abort_done", 32'(if8.done), 32'd0);
    check_val("abort_ready", 32'(if8.ready), 32'd1);
    check_val("abort_busy", 32'(if8.busy), 32'd0);
    check_val("abort_diff", 32'(if8.diff), 32'd0);
    check_val("abort_borrow", 32'(if8.borrow), 32'd0);
    check_val("abort_zero", 32'(if8.zero), 32'd0);
    repeat (12) @(negedge clk);
    op8(8'd200, 8'd1);

    // Random operations at both widths.
    for (int i = 0; i < 1000; i++) op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 1000; i++) op2(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

    repeat (3) @(negedge clk);
    check_val("q8_drained", 32'(q8.size()), 32'd0);
    check_val("q2_drained", 32'(q2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
